// File: rtl/iter_shift_unit.sv
// rtl/iter_shift_unit.sv - multi-cycle shift/rotate unit with start/busy/done handshake
module iter_shift_unit #(
    parameter int WIDTH = 32,
    parameter int STEP  = 1
) (
    input  logic             clock,
    input  logic             clear,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] data_in,
    input  logic [WIDTH-1:0] amount,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             carry_out
);

    localparam int CW = $clog2(WIDTH);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [2:0] OP_SHR  = 3'b000;
    localparam logic [2:0] OP_SHRA = 3'b001;
    localparam logic [2:0] OP_SHL  = 3'b010;
    localparam logic [2:0] OP_ROR  = 3'b011;
    localparam logic [2:0] OP_ROL  = 3'b100;

    localparam logic [CW:0] STEP_W = (CW+1)'(STEP);

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] work_q, work_d;
    logic [2:0]       op_q, op_d;
    logic [CW-1:0]    count_q, count_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             carry_q, carry_d;

    logic [CW-1:0]    k;
    logic [CW-1:0]    step_s;
    logic [CW-1:0]    inv_s;
    logic [CW-1:0]    idx_r;
    logic [WIDTH-1:0] shifted;
    logic             carry_bit;

    logic             unused_amount_hi;
    assign unused_amount_hi = ^amount[WIDTH-1:CW];

    // count never reaches WIDTH, so step_s fits in CW bits even when STEP == WIDTH
    always_comb begin
        k         = amount[CW-1:0];
        step_s    = ({1'b0, count_q} < STEP_W) ? count_q : STEP_W[CW-1:0];
        inv_s     = CW'(0) - step_s;
        idx_r     = step_s - CW'(1);
        shifted   = work_q;
        carry_bit = 1'b0;
        case (op_q)
            OP_SHR: begin
                shifted   = work_q >> step_s;
                carry_bit = work_q[idx_r];
            end
            OP_SHRA: begin
                shifted   = $signed(work_q) >>> step_s;
                carry_bit = work_q[idx_r];
            end
            OP_SHL: begin
                shifted   = work_q << step_s;
                carry_bit = work_q[inv_s];
            end
            OP_ROR: begin
                shifted   = (work_q >> step_s) | (work_q << inv_s);
                carry_bit = work_q[idx_r];
            end
            OP_ROL: begin
                shifted   = (work_q << step_s) | (work_q >> inv_s);
                carry_bit = work_q[inv_s];
            end
            default: begin
                shifted   = work_q;
                carry_bit = 1'b0;
            end
        endcase
    end

    always_comb begin
        state_d  = state_q;
        work_d   = work_q;
        op_d     = op_q;
        count_d  = count_q;
        result_d = result_q;
        carry_d  = carry_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    work_d  = data_in;
                    op_d    = op;
                    count_d = k;
                    if ((k != '0) && (op <= OP_ROL)) begin
                        state_d = S_RUN;
                    end else begin
                        state_d  = S_DONE;
                        result_d = data_in;
                        carry_d  = 1'b0;
                    end
                end
            end
            S_RUN: begin
                work_d  = shifted;
                count_d = count_q - step_s;
                // result/carry only move on the final step so no partial value is visible
                if (count_q == step_s) begin
                    state_d  = S_DONE;
                    result_d = shifted;
                    carry_d  = carry_bit;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            state_q  <= S_IDLE;
            work_q   <= '0;
            op_q     <= '0;
            count_q  <= '0;
            result_q <= '0;
            carry_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            work_q   <= work_d;
            op_q     <= op_d;
            count_q  <= count_d;
            result_q <= result_d;
            carry_q  <= carry_d;
        end
    end

    assign busy      = (state_q != S_IDLE);
    assign done      = (state_q == S_DONE);
    assign result    = result_q;
    assign carry_out = carry_q;

endmodule

// File: doc/iter_shift_unit.md
Name: iter_shift_unit

Overview:
Parametrised multi-cycle shift/rotate unit for the Mini SRC datapath. It is the sequential successor to the single-cycle ROR path in the ALU.
- Covers five modes: SHR, SHRA, SHL, ROR, ROL.
- Width and bits-shifted-per-cycle are configurable.
- Uses a start/busy/done handshake so the control unit can stall T-steps until the result is ready.
- Sits beside the ALU. Its result is captured into Z by the control step that follows done.

Parameters:
WIDTH, 32, operand/result width in bits; power of 2, >= 4.
STEP, 1, bits shifted per RUN cycle; power of 2, 1..WIDTH.

Ports:
clock  in  1  system clock, rising edge.
clear  in  1  asynchronous active-low reset.
start  in  1  request; sampled only in IDLE.
op  in  3  000 SHR, 001 SHRA, 010 SHL, 011 ROR, 100 ROL, 101-111 pass-through.
data_in  in  WIDTH  operand (Y-side value).
amount  in  WIDTH  shift count register value; only low log2(WIDTH) bits used.
busy  out  1  high whenever state != IDLE.
done  out  1  one-cycle pulse; result valid.
result  out  WIDTH  shifted value; held until next accepted start.
carry_out  out  1  last bit shifted or rotated out; 0 if effective count is 0 or pass-through.

Behaviour:
- Reset (clear=0, async): state=IDLE; busy=0, done=0, result=0, carry_out=0, internal count=0.
- Effective count k = amount mod WIDTH, i.e. the low log2(WIDTH) bits. Upper amount bits are ignored.
- States: IDLE, RUN, DONE.
- IDLE, start=1 at edge E0:
  - latch data_in into the working register, op into the op register, k into the count register.
  - go to RUN if k>0 and op is legal; otherwise go to DONE.
  - for k=0 or pass-through: result=data_in, carry_out=0.
- RUN, each edge:
  - s = min(STEP, count). Shift the working register by s per the latched op; count -= s.
  - carry_out = last bit leaving the word: bit s-1 for right ops, bit WIDTH-s for left ops.
  - when count reaches 0 on this edge, go to DONE.
- DONE: done=1 for exactly one cycle; result = working register; next edge goes to IDLE.
- Latency: done is high in the cycle after edge E(ceil(k/STEP)). For k=0 or pass-through, done is high in the cycle after E0.
- Shift semantics:
  - SHR: zero fill.
  - SHRA: MSB (sign) replicated.
  - SHL: zero fill.
  - ROR/ROL: bits wrap around; rotation by k equals the single-cycle rotate by k.
- start while busy (RUN or DONE) is ignored, not queued. A new start is accepted in IDLE the cycle after DONE.
- data_in, amount and op may change after E0 without affecting the operation in progress.
- result and carry_out are stable from DONE until the next accepted start. They are not cleared on return to IDLE.
- clear asserted mid-RUN or in DONE: immediate return to reset values. A partial result is never presented and done does not pulse.
- Outputs are registered; no combinational path from inputs to outputs.

Test Plan:
1. WIDTH=32, STEP=1; ROR, data_in=0x12345678, amount=8; start at E0 -> busy high after E0, done pulses in the cycle after E8, result=0x78123456, carry_out=0.
2. SHRA, data_in=0x80000000, amount=4, STEP=1 -> result=0xF8000000, done after E4.
3. SHL, data_in=0x00000003, amount=31, STEP=4 -> result=0x80000000, carry_out=1, done after E8 (ceil(31/4)).
4. ROL, data_in=0xA5A5A5A5, amount=36 (k=4) -> result=0x5A5A5A5A. Same op with amount=32 (k=0) -> result=0xA5A5A5A5, carry_out=0, done after E0.
5. Start SHR with data_in=0xFFFFFFFF, amount=16; pulse start again during RUN; hold clear low for 5 ns at E5 -> second start ignored; after clear: busy=0, done never pulsed, result=0.
6. Back-to-back ops: issue the next start in the IDLE cycle after done, with op=110 (pass-through) -> result=data_in, done one cycle later. Repeat the test 1 sweep with STEP=2, 8, 32: result identical, latencies 4, 1, 1.
